// File: rtl/jugada_pkg.sv
// Shared types for the move-receive path: column code, capture FSM states, default column count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jugada_pkg;

    typedef logic [2:0] col_t;

    localparam int NUM_COLS_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STABLE,
        CHECK
    } rx_state_t;

endpackage

// File: rtl/jugada_fifo.sv
// Generic circular FIFO of column codes with extra-MSB pointers for full/empty.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: push while full and pop while empty are ignored; the caller gates with full/empty.
//
// Ports: clk, rst (async active-low), push/push_dat, pop/pop_dat (head, 0 when empty),
//        full, empty, count (occupancy, $clog2(DEPTH)+1 bits).
module jugada_fifo
    import jugada_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  col_t                     push_dat,
    input  logic                     pop,
    output col_t                     pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    col_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra bit so full and empty are distinguishable when the
    // index bits coincide.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Gated to 0 when empty so the output is clean after reset without clearing memory.
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/jugada_rx_queue.sv
// Syncs SPI move code/flag into clk, waits for a stable code, range-checks it and queues it.
// Latency: 2 + STABLE_CYCLES + 1 clk from synced recibido rise to mov_valid (empty queue).
// Backpressure: mov_valid/mov_ready drain; a full queue drops the move and pulses err_overflow.
//
// Ports: clk, rst (async active-low); jugada_in/recibido_in (async to clk);
//        mov_col/mov_valid/mov_ready (queue head handshake); err_invalid/err_overflow (1-cycle
//        pulses); fifo_count (occupancy). Optional macro JUGADA_RX_STATS_EN adds
//        moves_total (wrapping) and errors_total (saturating) 8-bit counters.
module jugada_rx_queue
    import jugada_pkg::*;
#(
    parameter int NUM_COLS      = NUM_COLS_DEFAULT,
    parameter int FIFO_DEPTH    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    jugada_in,
    input  logic                          recibido_in,
    output logic [2:0]                    mov_col,
    output logic                          mov_valid,
    input  logic                          mov_ready,
    output logic                          err_invalid,
    output logic                          err_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef JUGADA_RX_STATS_EN
    ,
    output logic [7:0]                    moves_total,
    output logic [7:0]                    errors_total
`endif
);

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] NUM_COLS_W  = 4'(NUM_COLS);

    // ---------------- synchronisers and edge detect ----------------
    col_t       jug_s1, jug_s2;
    logic       rec_s1, rec_s2, rec_s3;
    logic       evt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jug_s1 <= '0;
            jug_s2 <= '0;
            rec_s1 <= 1'b0;
            rec_s2 <= 1'b0;
            rec_s3 <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            jug_s1 <= jugada_in;
            jug_s2 <= jug_s1;
            rec_s1 <= recibido_in;
            rec_s2 <= rec_s1;
            rec_s3 <= rec_s2;
            // Registered rise pulse; rec_s3 resets low, so a flag already high at
            // reset release still yields one event.
            evt_q  <= rec_s2 && !rec_s3;
        end
    end

    // ---------------- capture FSM ----------------
    rx_state_t  state, state_nxt;
    logic [3:0] stable_cnt;
    col_t       ref_col;
    col_t       capture_q;
    logic       match;
    logic       code_bad;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_vld;

    assign match    = (jug_s2 == ref_col);
    assign code_bad = ({1'b0, capture_q} >= NUM_COLS_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (evt_q) state_nxt = WAIT_STABLE;
            WAIT_STABLE: if (match && stable_cnt == STABLE_LAST) state_nxt = CHECK;
            CHECK:       state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Stability tracking: any change of the synced code restarts the count from the new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_cnt <= '0;
            ref_col    <= '0;
            capture_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (evt_q) begin
                        stable_cnt <= '0;
                        ref_col    <= jug_s2;
                    end
                end
                WAIT_STABLE: begin
                    if (match) begin
                        if (stable_cnt == STABLE_LAST) capture_q  <= ref_col;
                        else                           stable_cnt <= stable_cnt + 4'd1;
                    end else begin
                        ref_col    <= jug_s2;
                        stable_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decision uses the pre-pop full flag: a pop in the same cycle does not rescue the move.
    always_comb begin
        err_invalid  = 1'b0;
        err_overflow = 1'b0;
        push_vld     = 1'b0;
        if (state == CHECK) begin
            if (code_bad)       err_invalid  = 1'b1;
            else if (fifo_full) err_overflow = 1'b1;
            else                push_vld     = 1'b1;
        end
    end

    // ---------------- move queue ----------------
    assign mov_valid = !fifo_empty;

    jugada_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat (capture_q),
        .pop      (mov_valid && mov_ready),
        .pop_dat  (mov_col),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef JUGADA_RX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            moves_total  <= '0;
            errors_total <= '0;
        end else begin
            if (push_vld) moves_total <= moves_total + 8'd1;
            if ((err_invalid || err_overflow) && errors_total != 8'hFF)
                errors_total <= errors_total + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jugada_rx_queue.sv
// Scoreboard bench for jugada_rx_queue: directed moves, errors, wrap, reset.
// Latency: expects 2 + STABLE_CYCLES + 1 cycles from synced edge to mov_valid.
// Backpressure: consumer mov_ready driven by stimulus; monitor checks every handshake.
module tb_jugada_rx_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] jugada_in;
    logic       recibido_in;
    logic [2:0] mov_col;
    logic       mov_valid;
    logic       mov_ready;
    logic       err_invalid;
    logic       err_overflow;
    logic [2:0] fifo_count;
`ifdef JUGADA_RX_STATS_EN
    logic [7:0] moves_total;
    logic [7:0] errors_total;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] exp_col[$];
    logic [1:0] exp_err[$];   // 1 = invalid, 2 = overflow

    always #5 clk = ~clk;

    jugada_rx_queue dut (
        .clk          (clk),
        .rst          (rst),
        .jugada_in    (jugada_in),
        .recibido_in  (recibido_in),
        .mov_col      (mov_col),
        .mov_valid    (mov_valid),
        .mov_ready    (mov_ready),
        .err_invalid  (err_invalid),
        .err_overflow (err_overflow),
        .fifo_count   (fifo_count)
`ifdef JUGADA_RX_STATS_EN
        ,
        .moves_total  (moves_total),
        .errors_total (errors_total)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full move: code set a cycle ahead, flag held until the push is done, then released.
    task automatic send_move(input logic [2:0] c);
        jugada_in = c;
        step(1);
        recibido_in = 1'b1;
        step(9);
        recibido_in = 1'b0;
        step(4);
    endtask

    task automatic drain(input int n);
        mov_ready = 1'b1;
        step(n);
        mov_ready = 1'b0;
    endtask

    // Monitor: every accepted head and every error pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mov_valid && mov_ready) begin
                if (exp_col.size() == 0) chk("pop_unexpected", int'(mov_col), -1);
                else                     chk("pop_col", int'(mov_col), int'(exp_col.pop_front()));
            end
            if (err_invalid || err_overflow) begin
                if (exp_err.size() == 0) chk("err_unexpected", int'({err_overflow, err_invalid}), 0);
                else                     chk("err_kind", int'({err_overflow, err_invalid}), int'(exp_err.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        jugada_in   = 3'd0;
        recibido_in = 1'b0;
        mov_ready   = 1'b0;

        // Reset held with random inputs: every output must be zero.
        for (int i = 0; i < 5; i++) begin
            jugada_in   = 3'($urandom_range(7, 0));
            recibido_in = 1'($urandom_range(1, 0));
            mov_ready   = 1'($urandom_range(1, 0));
            @(negedge clk);
            chk("reset_outputs", int'({mov_valid, mov_col, err_invalid, err_overflow, fifo_count}), 0);
            step(1);
        end
        jugada_in   = 3'd0;
        recibido_in = 1'b0;
        mov_ready   = 1'b0;
        step(1);
        rst = 1'b1;
        step(10);
        @(negedge clk);
        chk("post_reset_valid", int'(mov_valid), 0);

        // Single move with exact latency.
        step(1);
        jugada_in = 3'd4;
        step(1);
        recibido_in = 1'b1;
        exp_col.push_back(3'd4);
        step(7);
        @(negedge clk);
        chk("single_early_valid", int'(mov_valid), 0);
        step(1);
        @(negedge clk);
        chk("single_valid", int'(mov_valid), 1);
        chk("single_col", int'(mov_col), 4);
        chk("single_count", int'(fifo_count), 1);
        step(1);
        mov_ready = 1'b1;
        step(1);
        mov_ready = 1'b0;
        @(negedge clk);
        chk("single_pop_valid", int'(mov_valid), 0);
        chk("single_pop_count", int'(fifo_count), 0);
        step(1);
        recibido_in = 1'b0;
        step(4);

        // Invalid code: one-cycle err_invalid, nothing queued.
        jugada_in = 3'd7;
        step(1);
        recibido_in = 1'b1;
        exp_err.push_back(2'd1);
        step(7);
        @(negedge clk);
        chk("invalid_pulse", int'(err_invalid), 1);
        step(1);
        @(negedge clk);
        chk("invalid_pulse_end", int'(err_invalid), 0);
        chk("invalid_count", int'(fifo_count), 0);
        step(1);
        recibido_in = 1'b0;
        step(4);

        // Glitching code during WAIT_STABLE delays the capture by the restart.
        jugada_in = 3'd2;
        step(1);
        recibido_in = 1'b1;
        exp_col.push_back(3'd2);
        step(3);
        jugada_in = 3'd5;
        step(1);
        jugada_in = 3'd2;
        step(6);
        @(negedge clk);
        chk("glitch_early_valid", int'(mov_valid), 0);
        step(1);
        @(negedge clk);
        chk("glitch_valid", int'(mov_valid), 1);
        step(1);
        drain(1);
        recibido_in = 1'b0;
        step(4);

        // Overflow: four queued, fifth dropped.
        for (int i = 0; i < 4; i++) begin
            exp_col.push_back(3'(i));
            send_move(3'(i));
        end
        exp_err.push_back(2'd2);
        send_move(3'd6);
        @(negedge clk);
        chk("overflow_count", int'(fifo_count), 4);
        step(1);
        drain(4);
        @(negedge clk);
        chk("drain_count", int'(fifo_count), 0);
        step(1);

        // Six more with pointer wrap.
        begin
            logic [2:0] wrap_vals [6];
            wrap_vals = '{3'd5, 3'd1, 3'd6, 3'd0, 3'd3, 3'd2};
            for (int i = 0; i < 4; i++) begin
                exp_col.push_back(wrap_vals[i]);
                send_move(wrap_vals[i]);
            end
            @(negedge clk);
            chk("wrap_full_count", int'(fifo_count), 4);
            step(1);
            drain(4);
            for (int i = 4; i < 6; i++) begin
                exp_col.push_back(wrap_vals[i]);
                send_move(wrap_vals[i]);
            end
            drain(2);
        end

        // Push in CHECK coincides with a pop at count 2.
        exp_col.push_back(3'd4);
        send_move(3'd4);
        exp_col.push_back(3'd5);
        send_move(3'd5);
        jugada_in = 3'd6;
        step(1);
        recibido_in = 1'b1;
        exp_col.push_back(3'd6);
        step(7);
        mov_ready = 1'b1;
        @(negedge clk);
        chk("simul_pre_count", int'(fifo_count), 2);
        step(1);
        mov_ready = 1'b0;
        @(negedge clk);
        chk("simul_post_count", int'(fifo_count), 2);
        step(1);
        recibido_in = 1'b0;
        step(4);
        drain(2);

        // Reset in WAIT_STABLE: no push afterwards.
        jugada_in = 3'd3;
        step(1);
        recibido_in = 1'b1;
        step(5);
        rst = 1'b0;
        recibido_in = 1'b0;
        step(1);
        @(negedge clk);
        chk("midreset_outputs", int'({mov_valid, mov_col, err_invalid, err_overflow, fifo_count}), 0);
        step(2);
        rst = 1'b1;
        step(15);
        @(negedge clk);
        chk("midreset_no_push_count", int'(fifo_count), 0);
        chk("midreset_no_push_valid", int'(mov_valid), 0);

        step(2);
        chk("scoreboard_cols_left", exp_col.size(), 0);
        chk("scoreboard_errs_left", exp_err.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jugada_rx_queue.md
Name: jugada_rx_queue

Overview:
- Downstream consumer of the SPI slave receiver. Takes its 3-bit `jugada` move code and `recibido` flag, both of which change on the SPI clock `sck`.
- Brings both into the `clk` domain, detects each new move, checks the column range, and queues valid moves in a small FIFO.
- The game-logic FSM drains the FIFO with a valid/ready handshake.

Parameters:
- NUM_COLS, 7, number of legal columns; a code is valid when jugada < NUM_COLS.
- FIFO_DEPTH, 4, queue entries; power of two, minimum 2.
- STABLE_CYCLES, 3, consecutive `clk` cycles the synced jugada must hold the same value before capture (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- jugada_in  in  3  move code from the SPI receiver; asynchronous to clk
- recibido_in  in  1  new-move flag from the SPI receiver; asynchronous to clk
- mov_col  out  3  column at the FIFO head
- mov_valid  out  1  FIFO not empty
- mov_ready  in  1  consumer accepts the head this cycle
- err_invalid  out  1  one-cycle pulse: captured code >= NUM_COLS, move dropped
- err_overflow  out  1  one-cycle pulse: valid move dropped because the FIFO is full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Synchronisation: jugada_in and recibido_in each pass through a 2-FF synchroniser. A third recibido stage provides edge detection. An event is a synced 0->1 transition of recibido.
- FSM states: IDLE, WAIT_STABLE, CHECK.
  - IDLE: on an event -> WAIT_STABLE; the stability counter loads 0 and the reference value loads synced jugada.
  - WAIT_STABLE: each cycle, if synced jugada equals the reference, the counter increments; otherwise the reference reloads and the counter clears. When the counter reaches STABLE_CYCLES-1 with a match -> CHECK and the reference is latched as the capture.
  - CHECK: exactly one cycle, then -> IDLE.
    - capture >= NUM_COLS: err_invalid pulses, nothing is pushed.
    - FIFO full: err_overflow pulses, nothing is pushed.
    - otherwise: the capture is pushed.
  - Events that arrive while not in IDLE are ignored (no queueing of edges).
- Minimum latency from a synced recibido rising edge to mov_valid with an empty FIFO is 2 + STABLE_CYCLES + 1 cycles.
  - The 2 is the edge-detect register plus the IDLE->WAIT_STABLE transition.
  - The final +1 is the registered FIFO write.
- FIFO:
  - Circular buffer, write/read pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full: pointer MSBs differ and the lower bits are equal. empty: pointers equal.
  - mov_col is driven combinationally from mem[rd_ptr]. A pop happens when mov_valid && mov_ready.
  - Push and pop in the same cycle: both are performed and the count is unchanged.
  - While full, a push in CHECK is decided on the pre-pop full flag, so it overflows even if a pop occurs that same cycle.
  - mov_ready while empty has no effect.
  - mov_col is held stable while mov_valid=1 and mov_ready=0.
- Reset (rst=0, any time, including mid-capture):
  - all synchroniser flops clear; the FSM returns to IDLE; pointers clear;
  - mov_valid=0, mov_col=0, err_invalid=0, err_overflow=0, fifo_count=0.
  - FIFO memory contents do not need to be cleared.
  - The recibido edge-detector clears to 0, so a recibido_in that is already 1 at reset release produces one event.
- Error pulses last exactly one cycle and are mutually exclusive.

Optional Feature:
- Macro: JUGADA_RX_STATS_EN.
- Defined:
  - adds output moves_total (8 bits, +1 per successful push, wraps 255->0);
  - adds output errors_total (8 bits, +1 per err_invalid or err_overflow pulse, saturates at 255);
  - both counters clear on reset.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package jugada_pkg holds:
  - typedef col_t (logic [2:0]);
  - localparam NUM_COLS_DEFAULT=7;
  - enum rx_state_t {IDLE, WAIT_STABLE, CHECK}.
- Sub-module jugada_fifo holds the generic FIFO (parameter DEPTH, data type col_t; push/pop/full/empty/count).
- The synchronisers and FSM stay in the top module.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release rst with recibido_in=0 -> mov_valid stays 0.
- Single move: jugada_in=3'd4, then recibido_in 0->1, consumer mov_ready=0 -> mov_valid=1 with mov_col=4 exactly 2+STABLE_CYCLES+1 cycles after the synced edge; fifo_count=1. Raise mov_ready for 1 cycle -> mov_valid=0, fifo_count=0.
- Invalid code: jugada_in=3'd7 with an event -> err_invalid high for exactly 1 cycle, fifo_count unchanged.
- Glitching data: toggle jugada_in 2->5->2 during WAIT_STABLE, then hold 2 -> capture only after STABLE_CYCLES consecutive matching cycles; mov_col=2.
- Overflow and wrap: push 4 moves (0,1,2,3) with mov_ready=0, then a 5th (6) -> err_overflow pulses, fifo_count=4. Pop all -> order 0,1,2,3. Push 6 more -> pointers wrap and order is preserved.
- Simultaneous push/pop and reset mid-capture:
  - FIFO count 2, CHECK push coincides with a pop -> count stays 2.
  - Assert rst during WAIT_STABLE -> FSM in IDLE, no push after release.
